sift_pipe_sequencer: RTL
========================

Name: sift_pipe_sequencer

Overview:
Top-level scheduler for the SIFT core datapath. It sequences one frame through three phases:
- streams row addresses of the original-image memory to the four gaussian engines (3x3, 5x5, 5x5, 7x7) in lockstep;
- launches the DoG detect/filter unit;
- gates and counts keypoint writes to the two keypoint memories.

It produces the gaussian_done and detect_filter_done status used by the rest of the core.

Parameters:
ROWS, 480, image rows per frame
ROW_AW, 9, row address width (holds ROWS-1)
N_ENG, 4, number of gaussian engines sharing the row stream
MAX_KPT, 2000, capacity of each keypoint memory
KPT_AW, 11, keypoint count width (holds MAX_KPT)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  frame start request, level; a rising edge is a start
row_req  out  1  row read request to ori_img and the gaussian engines
row_addr  out  ROW_AW  row index being presented
blur_ack  in  N_ENG  per-engine single-cycle ack meaning "current row consumed"
gaussian_done  out  N_ENG  per-engine sticky "last row consumed"
detect_start  out  1  one-cycle pulse launching the detect filter
detect_done  in  1  detect filter finished (pulse or level)
kpt_wr_req  in  2  keypoint write requests, layer 1 / layer 2
kpt_wr_gnt  out  2  combinational write enable into keypoint_1_mem / keypoint_2_mem
kpt_addr_0  out  KPT_AW  next write address, layer 1
kpt_addr_1  out  KPT_AW  next write address, layer 2
kpt_full  out  2  count for the layer has reached MAX_KPT
detect_filter_done  out  1  frame complete
busy  out  1  high in every state except IDLE and DONE
err  out  1  sticky error flag

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: every output 0, state IDLE, ack_seen 0, in_valid_q 0.
- Start detection: in_valid_q registers in_valid. start = in_valid & ~in_valid_q.
- FSM states: IDLE, BLUR, DETECT_LAUNCH, DETECT_WAIT, DONE.
- IDLE:
  - On start: clear gaussian_done, kpt counts, kpt_full and err.
  - Set row_addr=0 and go to BLUR; row_req is high in the next cycle.
- BLUR, row_req=1:
  - ack_seen[N_ENG-1:0] accumulates blur_ack as sticky bits. all_ack = &(ack_seen | blur_ack).
  - On all_ack with row_addr<ROWS-1: increment row_addr and clear ack_seen. row_req stays 1, so the next row is presented the following cycle with zero bubble.
  - On all_ack with row_addr==ROWS-1: set gaussian_done[k] for every engine; row_req=0 next cycle; go to DETECT_LAUNCH.
  - A duplicate ack from an engine already in ack_seen is ignored and not counted twice.
  - blur_ack outside BLUR is ignored.
- DETECT_LAUNCH: detect_start=1 for exactly one cycle, then DETECT_WAIT.
- DETECT_WAIT:
  - kpt_wr_gnt[i] = kpt_wr_req[i] & ~kpt_full[i].
  - Each grant increments kpt_addr_i at the clock edge.
  - kpt_full[i] is set when kpt_addr_i reaches MAX_KPT; it saturates there and further requests are dropped with no grant.
  - On detect_done: go to DONE. A write granted in the same cycle as detect_done is still counted.
- DONE:
  - detect_filter_done=1 and busy=0.
  - Stay until in_valid==0, then go to IDLE; detect_filter_done clears on the IDLE entry.
  - gaussian_done, kpt_addr_* and kpt_full hold their values until the next start.
- Grants: kpt_wr_gnt=0 in every state except DETECT_WAIT.
- Start while busy: ignored. No restart is possible mid-frame.
- Reset mid-frame: immediate return to IDLE with all outputs 0, including row_req. A frame is restarted only by a new in_valid rising edge after reset is released.
- Latency with zero-latency acks: ROWS cycles in BLUR, +1 cycle launch, +N cycles for the detect duration, +1 cycle to DONE.

Optional Feature:
SIFT_SEQ_WDOG_EN
- With the macro defined:
  - A 16-bit watchdog counter clears on any change of ack_seen, any grant, and on every state entry.
  - It increments in BLUR and DETECT_WAIT.
  - At 16'hFFFF: set err, force state DONE, drop row_req; gaussian_done bits stay as already set.
- Without the macro: no counter exists, err stays 0 permanently, and a stalled engine hangs the FSM in BLUR.

Test Plan:
1. ROWS=8, all four engines ack in the same cycle each row -> row_addr 0..7 on consecutive cycles; gaussian_done=4'hF after the 8th ack; detect_start pulses exactly once, 1 cycle later.
2. ROWS=8, engines ack row 3 staggered at offsets +0/+2/+5/+9 cycles, with engine 1 acking twice -> row_addr stays 3 for 10 cycles, then advances to 4; no row skipped.
3. MAX_KPT=4, kpt_wr_req=2'b11 for 6 cycles in DETECT_WAIT -> exactly 4 grants per layer; kpt_addr_0=kpt_addr_1=4; kpt_full=2'b11; last 2 requests not granted.
4. detect_done asserted in the same cycle as a granted write -> count includes that write; DONE next cycle with detect_filter_done=1; drop in_valid -> IDLE and detect_filter_done=0 one cycle later.
5. rst_n low at row 5 of BLUR -> row_req=0 and gaussian_done=0 immediately (async); after release, in_valid held high produces no restart; an in_valid 0->1 toggle restarts at row 0.
6. SIFT_SEQ_WDOG_EN defined, engine 2 never acks row 0 -> err=1 and detect_filter_done=1 after 65535 stall cycles; without the macro, still in BLUR with err=0.

Source files
------------

// File: rtl/sift_pipe_sequencer.sv
// Frame sequencer for the SIFT core: lockstep row stream to the gaussian engines, detect launch, keypoint write gating.
// Latency: ROWS cycles of row stream with zero-latency acks, +1 launch, +detect duration, +1 to DONE.
// Backpressure: a row is held until every engine has acked it; optional stall watchdog under `SIFT_SEQ_WDOG_EN.
module sift_pipe_sequencer #(
    parameter int ROWS    = 480,
    parameter int ROW_AW  = 9,
    parameter int N_ENG   = 4,
    parameter int MAX_KPT = 2000,
    parameter int KPT_AW  = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              row_req,
    output logic [ROW_AW-1:0] row_addr,
    input  logic [N_ENG-1:0]  blur_ack,
    output logic [N_ENG-1:0]  gaussian_done,
    output logic              detect_start,
    input  logic              detect_done,
    input  logic [1:0]        kpt_wr_req,
    output logic [1:0]        kpt_wr_gnt,
    output logic [KPT_AW-1:0] kpt_addr_0,
    output logic [KPT_AW-1:0] kpt_addr_1,
    output logic [1:0]        kpt_full,
    output logic              detect_filter_done,
    output logic              busy,
    output logic              err
);
    typedef enum logic [2:0] {IDLE, BLUR, DETECT_LAUNCH, DETECT_WAIT, DONE} state_t;

    localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(ROWS - 1);
    localparam logic [KPT_AW-1:0] KPT_CAP  = KPT_AW'(MAX_KPT);

    state_t           state, state_nxt;
    logic             in_valid_q;
    logic             armed;
    logic             start;
    logic [N_ENG-1:0] ack_seen, ack_seen_nxt;
    logic             all_ack;
    logic             last_row;
    logic             row_adv;
    logic             frame_end;
    logic             wdog_fire;

    // armed blocks a level held high across reset from looking like a fresh rising edge
    assign start     = in_valid & ~in_valid_q & armed;
    assign all_ack   = &(ack_seen | blur_ack);
    assign last_row  = (row_addr == LAST_ROW);
    assign row_adv   = (state == BLUR) && all_ack && !last_row && !wdog_fire;
    assign frame_end = (state == BLUR) && all_ack && last_row && !wdog_fire;
    assign kpt_full  = {kpt_addr_1 == KPT_CAP, kpt_addr_0 == KPT_CAP};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:          if (start) state_nxt = BLUR;
            BLUR:          if (frame_end) state_nxt = DETECT_LAUNCH;
            DETECT_LAUNCH: state_nxt = DETECT_WAIT;
            DETECT_WAIT:   if (detect_done) state_nxt = DONE;
            DONE:          if (!in_valid) state_nxt = IDLE;
            default:       state_nxt = IDLE;
        endcase
        if (wdog_fire) state_nxt = DONE;
    end

    always_comb begin
        row_req            = (state == BLUR);
        detect_start       = (state == DETECT_LAUNCH);
        detect_filter_done = (state == DONE);
        busy               = (state == BLUR) || (state == DETECT_LAUNCH) || (state == DETECT_WAIT);
        kpt_wr_gnt         = (state == DETECT_WAIT) ? (kpt_wr_req & ~kpt_full) : 2'b00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_valid_q <= 1'b0;
            armed      <= 1'b0;
        end else begin
            in_valid_q <= in_valid;
            if (!in_valid) armed <= 1'b1;
        end
    end

    always_comb begin
        ack_seen_nxt = ack_seen;
        if (state == IDLE && start) begin
            ack_seen_nxt = '0;
        end else if (state == BLUR) begin
            ack_seen_nxt = (row_adv || frame_end) ? '0 : (ack_seen | blur_ack);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_addr      <= '0;
            ack_seen      <= '0;
            gaussian_done <= '0;
        end else begin
            ack_seen <= ack_seen_nxt;
            if (state == IDLE && start) begin
                row_addr      <= '0;
                gaussian_done <= '0;
            end else if (row_adv) begin
                row_addr <= row_addr + ROW_AW'(1);
            end else if (frame_end) begin
                gaussian_done <= '1;
            end
        end
    end

    // grants are already masked by kpt_full, so the counters saturate at MAX_KPT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kpt_addr_0 <= '0;
            kpt_addr_1 <= '0;
        end else if (state == IDLE && start) begin
            kpt_addr_0 <= '0;
            kpt_addr_1 <= '0;
        end else begin
            if (kpt_wr_gnt[0]) kpt_addr_0 <= kpt_addr_0 + KPT_AW'(1);
            if (kpt_wr_gnt[1]) kpt_addr_1 <= kpt_addr_1 + KPT_AW'(1);
        end
    end

`ifdef SIFT_SEQ_WDOG_EN
    logic [15:0] wdog;
    logic        wdog_clr;
    logic        wdog_run;

    // any forward progress (ack, row advance, grant, state change) restarts the stall count
    assign wdog_clr  = (ack_seen_nxt != ack_seen) || row_adv || (|kpt_wr_gnt) || (state_nxt != state);
    assign wdog_run  = (state == BLUR) || (state == DETECT_WAIT);
    assign wdog_fire = wdog_run && (wdog == 16'hFFFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog <= '0;
        end else if (wdog_clr) begin
            wdog <= '0;
        end else if (wdog_run) begin
            wdog <= wdog + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (state == IDLE && start) begin
            err <= 1'b0;
        end else if (wdog_fire) begin
            err <= 1'b1;
        end
    end
`else
    assign wdog_fire = 1'b0;
    assign err       = 1'b0;
`endif

endmodule
